mem_boot_seq: RTL and testbench

- Sequences the shared dual-port Mem4K instruction port (port A) across three phases: program load, core run, RAM dump.
- Loads a program image from a word stream starting at LOAD_BASE, then releases the single-cycle core's reset and hands port A to instruction fetch.
- Detects halt (fetch address 0 or cycle budget exhausted), re-asserts core reset, and streams the whole RAM out for the dump file.
- Sits between Mem4K port A, the core's fetch port and the bench/host.

---
 rtl/mem_boot_seq_pkg.sv | 21 ++
 rtl/mem_boot_seq_if.sv | 22 ++
 rtl/mem_boot_dump.sv | 62 ++++++
 rtl/mem_boot_seq.sv | 142 ++++++++++++++
 tb/tb_mem_boot_seq.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_boot_seq_pkg.sv
// Shared definitions for the Mem4K boot sequencer: port A enable encoding, phase states
// and default geometry.
package mem_boot_seq_pkg;

  localparam logic MM_ENB_W = 1'b1;
  localparam logic MM_ENB_R = 1'b0;

  localparam int unsigned MEM_BYTES_DEF = 4096;
  localparam logic [31:0] LOAD_BASE_DEF = 32'h0000_0800;
  localparam int unsigned MAX_CYC_DEF   = 4096;

  typedef enum logic [2:0] {
    ST_LOAD = 3'd0,
    ST_RUN  = 3'd1,
    ST_DRD  = 3'd2,
    ST_DWT  = 3'd3,
    ST_DOUT = 3'd4,
    ST_DONE = 3'd5
  } boot_state_e;

endpackage

// File: rtl/mem_boot_seq_if.sv
// Host-side streams of the boot sequencer: program-word loader in, RAM dump out.
interface mem_boot_seq_if;
  logic        ld_valid;
  logic        ld_ready;
  logic [31:0] ld_data;
  logic        ld_last;
  logic        dump_valid;
  logic        dump_ready;
  logic [31:0] dump_addr;
  logic [31:0] dump_data;
  logic        dump_nz;

  modport master (
    input  ld_valid, ld_data, ld_last, dump_ready,
    output ld_ready, dump_valid, dump_addr, dump_data, dump_nz
  );

  modport slave (
    output ld_valid, ld_data, ld_last, dump_ready,
    input  ld_ready, dump_valid, dump_addr, dump_data, dump_nz
  );
endinterface

// File: rtl/mem_boot_dump.sv
// RAM dump walker: address counter plus the valid/ready output register for the
// DRD/DWT/DOUT phases. Phase sequencing itself lives in the parent FSM.
module mem_boot_dump
  import mem_boot_seq_pkg::*;
#(
  parameter int unsigned MEM_BYTES = MEM_BYTES_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  boot_state_e state,
  input  logic        start,
  input  logic [31:0] rd_data,
  input  logic        dump_ready,
  output logic [31:0] ptr,
  output logic        last,
  output logic        acc,
  output logic        dump_valid,
  output logic [31:0] dump_addr,
  output logic [31:0] dump_data,
  output logic        dump_nz
);

  localparam logic [31:0] LastAddr = 32'(MEM_BYTES - 4);

  logic [31:0] ptr_q;
  logic        valid_q;
  logic [31:0] addr_q;
  logic [31:0] data_q;

  assign ptr  = ptr_q;
  assign last = (ptr_q == LastAddr);
  assign acc  = (state == ST_DOUT) && valid_q && dump_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q   <= '0;
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      if (start) begin
        ptr_q <= '0;
      end else if (acc && !last) begin
        ptr_q <= ptr_q + 32'd4;
      end
      // Read data issued in DRD arrives during DWT
      if (state == ST_DWT) begin
        valid_q <= 1'b1;
        addr_q  <= ptr_q;
        data_q  <= rd_data;
      end else if (acc) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign dump_valid = valid_q;
  assign dump_addr  = addr_q;
  assign dump_data  = data_q;
  assign dump_nz    = (data_q != '0);

endmodule

// File: rtl/mem_boot_seq.sv
// Mem4K port A sequencer: program load, core run, RAM dump. Optional BOOT_CHECKSUM_EN adds
// the ld_sum / sum_ok load checksum outputs.
module mem_boot_seq
  import mem_boot_seq_pkg::*;
#(
  parameter int unsigned MEM_BYTES = MEM_BYTES_DEF,
  parameter logic [31:0] LOAD_BASE = LOAD_BASE_DEF,
  parameter int unsigned MAX_CYC   = MAX_CYC_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  mem_boot_seq_if.master        host,
  output logic                  core_rst,
  input  logic [31:0]           core_iaddr,
  output logic [31:0]           core_instr,
  output logic                  mem_en_wr,
  output logic [31:0]           mem_abus,
  output logic [31:0]           mem_dbus_w,
  input  logic [31:0]           mem_dbus_r,
`ifdef BOOT_CHECKSUM_EN
  output logic [31:0]           ld_sum,
  output logic                  sum_ok,
`endif
  output logic [31:0]           cnt,
  output logic                  done
);

  localparam logic [31:0] LastAddr = 32'(MEM_BYTES - 4);

  boot_state_e state_q, state_d;
  logic [31:0] ptr_q;
  logic [31:0] cnt_q;
  logic        ld_ready_q;
  logic        core_rst_q;
  logic        ld_acc;
  logic        halt;
  logic [31:0] dump_ptr;
  logic        dump_last;
  logic        dump_acc;

  assign ld_acc = (state_q == ST_LOAD) && host.ld_valid && ld_ready_q;
  assign halt   = (state_q == ST_RUN) &&
                  (((core_iaddr == '0) && !core_rst_q) || (cnt_q > MAX_CYC));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_LOAD: if (ld_acc && (host.ld_last || (ptr_q == LastAddr))) state_d = ST_RUN;
      ST_RUN:  if (halt) state_d = ST_DRD;
      ST_DRD:  state_d = ST_DWT;
      ST_DWT:  state_d = ST_DOUT;
      ST_DOUT: if (dump_acc) state_d = dump_last ? ST_DONE : ST_DRD;
      ST_DONE: state_d = ST_DONE;
      default: state_d = ST_LOAD;
    endcase
  end

  // Port A mux: loader writes, core fetch, dump reads; idle read at 0 otherwise
  always_comb begin
    mem_en_wr  = MM_ENB_R;
    mem_abus   = '0;
    mem_dbus_w = '0;
    case (state_q)
      ST_LOAD: begin
        if (ld_acc) begin
          mem_en_wr  = MM_ENB_W;
          mem_abus   = ptr_q;
          mem_dbus_w = host.ld_data;
        end
      end
      ST_RUN:  mem_abus = core_iaddr;
      ST_DRD:  mem_abus = dump_ptr;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_LOAD;
      ptr_q      <= LOAD_BASE;
      cnt_q      <= '0;
      ld_ready_q <= 1'b0;
      core_rst_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      ld_ready_q <= (state_d == ST_LOAD);
      core_rst_q <= (state_d != ST_RUN);
      if (ld_acc) ptr_q <= ptr_q + 32'd4;
      if ((state_q == ST_RUN) && (cnt_q != '1)) cnt_q <= cnt_q + 32'd1;
    end
  end

  mem_boot_dump #(
    .MEM_BYTES (MEM_BYTES)
  ) u_dump (
    .clk        (clk),
    .rst        (rst),
    .state      (state_q),
    .start      (halt),
    .rd_data    (mem_dbus_r),
    .dump_ready (host.dump_ready),
    .ptr        (dump_ptr),
    .last       (dump_last),
    .acc        (dump_acc),
    .dump_valid (host.dump_valid),
    .dump_addr  (host.dump_addr),
    .dump_data  (host.dump_data),
    .dump_nz    (host.dump_nz)
  );

`ifdef BOOT_CHECKSUM_EN
  logic [31:0] sum_q;
  logic [31:0] last_word_q;
  logic        has_last_q;

  // The ld_last word carries the expected sum and is excluded from it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q       <= '0;
      last_word_q <= '0;
      has_last_q  <= 1'b0;
    end else if (ld_acc) begin
      if (host.ld_last) begin
        last_word_q <= host.ld_data;
        has_last_q  <= 1'b1;
      end else begin
        sum_q <= sum_q + host.ld_data;
      end
    end
  end

  assign ld_sum = sum_q;
  assign sum_ok = (state_q != ST_LOAD) && has_last_q && (sum_q == last_word_q);
`endif

  assign host.ld_ready = ld_ready_q;
  assign core_rst      = core_rst_q;
  assign core_instr    = mem_dbus_r;
  assign cnt           = cnt_q;
  assign done          = (state_q == ST_DONE);

endmodule

// File: tb/tb_mem_boot_seq.sv
// Randomized bench for mem_boot_seq against a word-level RAM/boot reference model.
module tb_mem_boot_seq;
  import mem_boot_seq_pkg::*;

  localparam int unsigned MemBytes = 4096;
  localparam logic [31:0] LoadBase = 32'h800;
  localparam int unsigned MaxCyc   = 4096;
  localparam int          NWords   = MemBytes / 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        core_rst;
  logic [31:0] core_iaddr;
  logic [31:0] core_instr;
  logic        mem_en_wr;
  logic [31:0] mem_abus;
  logic [31:0] mem_dbus_w;
  logic [31:0] mem_dbus_r;
  logic [31:0] cnt;
  logic        done;
`ifdef BOOT_CHECKSUM_EN
  logic [31:0] ld_sum;
  logic        sum_ok;
`endif

  mem_boot_seq_if host ();

  mem_boot_seq #(
    .MEM_BYTES (MemBytes),
    .LOAD_BASE (LoadBase),
    .MAX_CYC   (MaxCyc)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .host       (host),
    .core_rst   (core_rst),
    .core_iaddr (core_iaddr),
    .core_instr (core_instr),
    .mem_en_wr  (mem_en_wr),
    .mem_abus   (mem_abus),
    .mem_dbus_w (mem_dbus_w),
    .mem_dbus_r (mem_dbus_r),
`ifdef BOOT_CHECKSUM_EN
    .ld_sum     (ld_sum),
    .sum_ok     (sum_ok),
`endif
    .cnt        (cnt),
    .done       (done)
  );

  always #5 clk = ~clk;

  // Mem4K port A stand-in: synchronous read, one-cycle latency
  logic [31:0] ram [NWords];
  logic        clr_ram = 1'b0;
  always @(posedge clk) begin
    if (clr_ram) begin
      for (int i = 0; i < NWords; i++) ram[i] <= '0;
    end else if (mem_en_wr == MM_ENB_W) begin
      ram[mem_abus[11:2]] <= mem_dbus_w;
    end
    mem_dbus_r <= ram[mem_abus[11:2]];
  end

  logic [31:0] ref_ram [NWords];
  logic [31:0] load_q [$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clr_ram = 1'b1;
    host.ld_valid = 1'b0;
    host.ld_last = 1'b0;
    host.ld_data = '0;
    host.dump_ready = 1'b0;
    core_iaddr = LoadBase;
    for (int i = 0; i < NWords; i++) ref_ram[i] = '0;
    repeat (2) @(negedge clk);
    #1;
    check_eq("rst_ld_ready", 32'(host.ld_ready), 32'd0);
    check_eq("rst_core_rst", 32'(core_rst), 32'd1);
    check_eq("rst_en_wr", 32'(mem_en_wr), 32'(MM_ENB_R));
    check_eq("rst_abus", mem_abus, 32'd0);
    check_eq("rst_dump_valid", 32'(host.dump_valid), 32'd0);
    check_eq("rst_dump_addr", host.dump_addr, 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_cnt", cnt, 32'd0);
    clr_ram = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    #1;
    check_eq("ld_ready_up", 32'(host.ld_ready), 32'd1);
  endtask

  // halt_after < 0: fetch never reaches 0, so the cycle budget ends the run
  task automatic run_boot(input bit last_flag, input int halt_after, input bit rand_gap,
                          input bit rand_rdy, input int rst_idx);
    int nw, run_n, exp_run, idx, cyc;
    logic [31:0] prev, hold_addr, hold_data, exp_sum;
    bit halted, held, aborted, exp_ok;
    nw = load_q.size();
    do_reset();
    exp_sum = '0;
    exp_ok = 1'b0;
    for (int i = 0; i < nw; i++) begin
      repeat (rand_gap ? $urandom_range(0, 2) : 0) begin
        @(negedge clk);
        host.ld_valid = 1'b0;
        #1;
        check_eq("idle_en_wr", 32'(mem_en_wr), 32'(MM_ENB_R));
      end
      @(negedge clk);
      host.ld_valid = 1'b1;
      host.ld_data = load_q[i];
      host.ld_last = last_flag && (i == nw - 1);
      #1;
      check_eq("ld_en_wr", 32'(mem_en_wr), 32'(MM_ENB_W));
      check_eq("ld_abus", mem_abus, LoadBase + 32'(4 * i));
      check_eq("ld_dbus_w", mem_dbus_w, load_q[i]);
      ref_ram[int'(LoadBase / 4) + i] = load_q[i];
      if (last_flag && i == nw - 1) exp_ok = (exp_sum == load_q[i]);
      else exp_sum += load_q[i];
    end

    run_n = 0;
    prev = '0;
    halted = 1'b0;
    while (!halted && run_n <= int'(MaxCyc) + 8) begin
      @(negedge clk);
      if (core_rst) begin
        halted = 1'b1;
      end else begin
        core_iaddr = (halt_after >= 0 && run_n >= halt_after) ? 32'h0
                   : LoadBase + 32'(4 * (run_n % nw));
        host.ld_valid = 1'b1;
        host.ld_data = 32'hdead_beef;
        host.ld_last = 1'b0;
        #1;
        check_eq("fetch_abus", mem_abus, core_iaddr);
        if (run_n == 0) begin
          check_eq("run_ld_ready", 32'(host.ld_ready), 32'd0);
          check_eq("run_en_wr", 32'(mem_en_wr), 32'(MM_ENB_R));
        end else begin
          check_eq("fetch_instr", core_instr, ref_ram[prev[11:2]]);
        end
        prev = core_iaddr;
        run_n++;
      end
    end
    exp_run = (halt_after >= 0) ? halt_after + 1 : int'(MaxCyc) + 2;
    check_eq("run_cycles", run_n, exp_run);
    check_eq("cnt_final", cnt, exp_run);
    #1;
    check_eq("drd_abus", mem_abus, 32'd0);
`ifdef BOOT_CHECKSUM_EN
    check_eq("ld_sum", ld_sum, exp_sum);
    check_eq("sum_ok", 32'(sum_ok), 32'(exp_ok));
`endif

    host.ld_valid = 1'b0;
    idx = 0;
    cyc = 0;
    held = 1'b0;
    aborted = 1'b0;
    hold_addr = '0;
    hold_data = '0;
    check_eq("dump_not_done", 32'(done), 32'd0);
    while (idx < NWords && cyc < 20 * NWords && !aborted) begin
      host.dump_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (held) begin
        check_eq("hold_valid", 32'(host.dump_valid), 32'd1);
        check_eq("hold_addr", host.dump_addr, hold_addr);
        check_eq("hold_data", host.dump_data, hold_data);
      end
      held = 1'b0;
      if (rst_idx == idx && host.dump_valid) begin
        rst = 1'b1;
        #1;
        check_eq("arst_core_rst", 32'(core_rst), 32'd1);
        check_eq("arst_dump_valid", 32'(host.dump_valid), 32'd0);
        check_eq("arst_dump_addr", host.dump_addr, 32'd0);
        check_eq("arst_cnt", cnt, 32'd0);
        check_eq("arst_done", 32'(done), 32'd0);
        aborted = 1'b1;
      end else if (host.dump_valid && host.dump_ready) begin
        check_eq("dump_addr", host.dump_addr, 32'(4 * idx));
        check_eq("dump_data", host.dump_data, ref_ram[idx]);
        check_eq("dump_nz", 32'(host.dump_nz), 32'(ref_ram[idx] != 0));
        idx++;
      end else if (host.dump_valid) begin
        held = 1'b1;
        hold_addr = host.dump_addr;
        hold_data = host.dump_data;
      end
      cyc++;
      if (!aborted) @(negedge clk);
    end
    check_eq("dump_words", idx, aborted ? rst_idx : NWords);
    if (aborted) begin
      @(negedge clk);
      rst = 1'b0;
    end else begin
      if (!rand_rdy) check_eq("dump_cycles", cyc, 3 * NWords);
      #1;
      check_eq("done_set", 32'(done), 32'd1);
      check_eq("done_no_valid", 32'(host.dump_valid), 32'd0);
      repeat (3) @(negedge clk);
      #1;
      check_eq("done_sticky", 32'(done), 32'd1);
      check_eq("done_core_rst", 32'(core_rst), 32'd1);
      check_eq("done_abus", mem_abus, 32'd0);
    end
  endtask

  task automatic fill_random(input int n);
    load_q.delete();
    repeat (n) load_q.push_back($urandom);
  endtask

  initial begin
    load_q = {32'h13, 32'h13, 32'h13, 32'h13};
    run_boot(1'b1, 2, 1'b0, 1'b0, -1);
    fill_random($urandom_range(1, 16));
    run_boot(1'b1, 0, 1'b1, 1'b1, -1);
    fill_random($urandom_range(1, 16));
    run_boot(1'b1, -1, 1'b1, 1'b1, 256);
    fill_random(NWords / 2);
    run_boot(1'b0, 5, 1'b0, 1'b0, -1);
    fill_random(NWords / 2);
    run_boot(1'b1, 0, 1'b0, 1'b1, 3);
`ifdef BOOT_CHECKSUM_EN
    load_q = {32'd1, 32'd2, 32'd3};
    run_boot(1'b1, 0, 1'b0, 1'b1, 0);
    load_q = {32'd1, 32'd2, 32'd4};
    run_boot(1'b1, 0, 1'b0, 1'b1, 0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
